// File: rtl/cond_logic_mc.sv
// Multicycle ARM condition logic: NZCV flag register, 16-way condition decode,
// write gating and a saved-flags stack. Optional macro: COND_FLAG_FWD_EN.
module cond_logic_mc #(
  parameter int CONDEX_LATCH = 1,
  parameter int SAVE_DEPTH   = 2,
  parameter int SDW          = $clog2(SAVE_DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic [3:0]     Cond,
  input  logic [3:0]     ALUFlags,
  input  logic [1:0]     FlagW,
  input  logic           PCS,
  input  logic           RegW,
  input  logic           MemW,
  input  logic           NoWrite,
  input  logic           CondSample,
  input  logic           FlagSave,
  input  logic           FlagRestore,
  output logic           PCSrc,
  output logic           RegWrite,
  output logic           MemWrite,
  output logic           CondEx,
  output logic [3:0]     Flags,
  output logic [SDW-1:0] SaveCount,
  output logic           SaveOvf,
  output logic           SaveUnf
);

  localparam logic [SDW-1:0] DEPTH_C = SDW'(SAVE_DEPTH);
  localparam logic [SDW-1:0] ONE_C   = SDW'(1);

  logic [3:0]      flags_reg, flags_next;
  logic            condex_reg, condex_next;
  logic [SDW-1:0]  count_reg, count_next;
  logic            ovf_reg, ovf_next;
  logic            unf_reg, unf_next;
  logic [3:0]      stack_reg [SAVE_DEPTH];

  logic [3:0]      eval_flags;
  logic            cond_comb;
  logic            condex;
  logic [1:0]      flag_write;
  logic [3:0]      top_entry;
  logic            has_entry;
  logic            is_full;
  logic            push;
  logic            swap;
  logic [SAVE_DEPTH-1:0] entry_we;

  logic fn, fz, fc, fv;
  assign {fn, fz, fc, fv} = eval_flags;

  always_comb begin
    cond_comb = 1'b0;
    unique case (Cond)
      4'h0: cond_comb = fz;
      4'h1: cond_comb = ~fz;
      4'h2: cond_comb = fc;
      4'h3: cond_comb = ~fc;
      4'h4: cond_comb = fn;
      4'h5: cond_comb = ~fn;
      4'h6: cond_comb = fv;
      4'h7: cond_comb = ~fv;
      4'h8: cond_comb = fc & ~fz;
      4'h9: cond_comb = ~fc | fz;
      4'hA: cond_comb = (fn == fv);
      4'hB: cond_comb = (fn != fv);
      4'hC: cond_comb = ~fz & (fn == fv);
      4'hD: cond_comb = fz | (fn != fv);
      4'hE: cond_comb = 1'b1;
      4'hF: cond_comb = 1'b0;
      default: cond_comb = 1'b0;
    endcase
  end

  assign flag_write = FlagW & {2{condex}};

  generate
    if (CONDEX_LATCH != 0) begin : g_latch
      assign condex = condex_reg;
`ifdef COND_FLAG_FWD_EN
      // Safe to forward: flag_write depends only on the registered CondEx here.
      assign eval_flags = {flag_write[1] ? ALUFlags[3:2] : flags_reg[3:2],
                           flag_write[0] ? ALUFlags[1:0] : flags_reg[1:0]};
`else
      assign eval_flags = flags_reg;
`endif
      assign condex_next = CondSample ? cond_comb : condex_reg;
    end else begin : g_comb
      logic unused_condsample;
      assign unused_condsample = CondSample;
      assign condex      = cond_comb;
      assign eval_flags  = flags_reg;
      assign condex_next = condex_reg;
    end
  endgenerate

  assign has_entry = (count_reg != '0);
  assign is_full   = (count_reg == DEPTH_C);

  always_comb begin
    top_entry = '0;
    for (int i = 0; i < SAVE_DEPTH; i++) begin
      if (count_reg == SDW'(i + 1)) top_entry = stack_reg[i];
    end
  end

  // Restore wins over flag writes; a lone save still lets the ALU update flags.
  always_comb begin
    flags_next = flags_reg;
    count_next = count_reg;
    ovf_next   = ovf_reg;
    unf_next   = unf_reg;
    push       = 1'b0;
    swap       = 1'b0;
    if (FlagRestore && FlagSave) begin
      if (has_entry) begin
        flags_next = top_entry;
        swap       = 1'b1;
      end else begin
        unf_next = 1'b1;
      end
    end else if (FlagRestore) begin
      if (has_entry) begin
        flags_next = top_entry;
        count_next = count_reg - ONE_C;
      end else begin
        unf_next = 1'b1;
      end
    end else begin
      if (FlagSave) begin
        if (is_full) begin
          ovf_next = 1'b1;
        end else begin
          push       = 1'b1;
          count_next = count_reg + ONE_C;
        end
      end
      if (flag_write[1]) flags_next[3:2] = ALUFlags[3:2];
      if (flag_write[0]) flags_next[1:0] = ALUFlags[1:0];
    end
  end

  // A push fills the slot at count; a swap overwrites the current top.
  generate
    for (genvar gi = 0; gi < SAVE_DEPTH; gi++) begin : g_entry_we
      assign entry_we[gi] = (push && (count_reg == SDW'(gi))) ||
                            (swap && (count_reg == SDW'(gi + 1)));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < SAVE_DEPTH; i++) stack_reg[i] <= '0;
    end else if (en) begin
      for (int i = 0; i < SAVE_DEPTH; i++) begin
        if (entry_we[i]) stack_reg[i] <= flags_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      flags_reg  <= '0;
      condex_reg <= 1'b0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
      unf_reg    <= 1'b0;
    end else if (en) begin
      flags_reg  <= flags_next;
      condex_reg <= condex_next;
      count_reg  <= count_next;
      ovf_reg    <= ovf_next;
      unf_reg    <= unf_next;
    end
  end

  assign CondEx    = condex;
  assign PCSrc     = PCS & condex;
  assign RegWrite  = RegW & ~NoWrite & condex;
  assign MemWrite  = MemW & condex;
  assign Flags     = flags_reg;
  assign SaveCount = count_reg;
  assign SaveOvf   = ovf_reg;
  assign SaveUnf   = unf_reg;

endmodule

// File: tb/tb_cond_logic_mc.sv
// Bench for cond_logic_mc: latched and combinational instances side by side,
// directed steps followed by random traffic against a queue-based flag model.
module tb_cond_logic_mc;

  logic       clk;
  logic       reset, en;
  logic [3:0] Cond, ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite, CondSample, FlagSave, FlagRestore;

  logic       pcsrc_1, regwrite_1, memwrite_1, condex_1, ovf_1, unf_1;
  logic [3:0] flags_1;
  logic [1:0] cnt_1;
  logic       pcsrc_0, regwrite_0, memwrite_0, condex_0, ovf_0, unf_0;
  logic [3:0] flags_0;
  logic [1:0] cnt_0;

  int n_cmp = 0;
  int n_err = 0;
  int n_step = 0;

  cond_logic_mc #(.CONDEX_LATCH(1), .SAVE_DEPTH(2)) u_dut1 (
    .clk(clk), .reset(reset), .en(en), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .CondSample(CondSample), .FlagSave(FlagSave), .FlagRestore(FlagRestore),
    .PCSrc(pcsrc_1), .RegWrite(regwrite_1), .MemWrite(memwrite_1),
    .CondEx(condex_1), .Flags(flags_1), .SaveCount(cnt_1),
    .SaveOvf(ovf_1), .SaveUnf(unf_1));

  cond_logic_mc #(.CONDEX_LATCH(0), .SAVE_DEPTH(2)) u_dut0 (
    .clk(clk), .reset(reset), .en(en), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
    .CondSample(CondSample), .FlagSave(FlagSave), .FlagRestore(FlagRestore),
    .PCSrc(pcsrc_0), .RegWrite(regwrite_0), .MemWrite(memwrite_0),
    .CondEx(condex_0), .Flags(flags_0), .SaveCount(cnt_0),
    .SaveOvf(ovf_0), .SaveUnf(unf_0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: [0] = combinational instance, [1] = latched instance.
  logic [3:0] mf [2];
  logic       mcx [2];
  logic       movf [2];
  logic       munf [2];
  logic [3:0] mq0 [$];
  logic [3:0] mq1 [$];

  // Condition pairs share a base test; odd codes invert it, 15 never runs.
  function automatic logic cond_of(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cf, v, base;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? !base : base;
  endfunction

  function automatic logic model_condex(input int k);
    return (k == 1) ? mcx[1] : cond_of(mf[0], Cond);
  endfunction

  task automatic model_update(input int k);
    logic [3:0] q [$];
    logic [3:0] f, ev, t;
    logic [1:0] fw;
    if (k == 0) q = mq0; else q = mq1;
    f  = mf[k];
    fw = FlagW & {2{model_condex(k)}};
    if (!reset) begin
      mf[k] = 4'h0; mcx[k] = 1'b0; movf[k] = 1'b0; munf[k] = 1'b0;
      q.delete();
    end else if (en) begin
      ev = f;
`ifdef COND_FLAG_FWD_EN
      if (k == 1) begin
        if (fw[1]) ev[3:2] = ALUFlags[3:2];
        if (fw[0]) ev[1:0] = ALUFlags[1:0];
      end
`endif
      if (k == 1 && CondSample) mcx[1] = cond_of(ev, Cond);
      if (FlagRestore && FlagSave) begin
        if (q.size() > 0) begin
          t = q[q.size()-1];
          q[q.size()-1] = f;
          mf[k] = t;
        end else munf[k] = 1'b1;
      end else if (FlagRestore) begin
        if (q.size() > 0) mf[k] = q.pop_back();
        else munf[k] = 1'b1;
      end else begin
        if (FlagSave) begin
          if (q.size() < 2) q.push_back(f);
          else movf[k] = 1'b1;
        end
        if (fw[1]) mf[k][3:2] = ALUFlags[3:2];
        if (fw[0]) mf[k][1:0] = ALUFlags[1:0];
      end
    end
    if (k == 0) mq0 = q; else mq1 = q;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic ce0, ce1;
    ce0 = model_condex(0);
    ce1 = model_condex(1);
    chk("condex0", 8'(condex_0), 8'(ce0));
    chk("pcsrc0", 8'(pcsrc_0), 8'(PCS & ce0));
    chk("regwrite0", 8'(regwrite_0), 8'(RegW & ~NoWrite & ce0));
    chk("memwrite0", 8'(memwrite_0), 8'(MemW & ce0));
    chk("flags0", 8'(flags_0), 8'(mf[0]));
    chk("count0", 8'(cnt_0), 8'(mq0.size()));
    chk("ovf0", 8'(ovf_0), 8'(movf[0]));
    chk("unf0", 8'(unf_0), 8'(munf[0]));
    chk("condex1", 8'(condex_1), 8'(ce1));
    chk("pcsrc1", 8'(pcsrc_1), 8'(PCS & ce1));
    chk("regwrite1", 8'(regwrite_1), 8'(RegW & ~NoWrite & ce1));
    chk("memwrite1", 8'(memwrite_1), 8'(MemW & ce1));
    chk("flags1", 8'(flags_1), 8'(mf[1]));
    chk("count1", 8'(cnt_1), 8'(mq1.size()));
    chk("ovf1", 8'(ovf_1), 8'(movf[1]));
    chk("unf1", 8'(unf_1), 8'(munf[1]));
  endtask

  // One transaction: compare mid-cycle, advance the model, clock the DUTs.
  task automatic step(input bit do_check);
    #1;
    if (do_check) check_all();
    $display("step %0d rst=%b en=%b cond=%h fw=%b alu=%h smp=%b sv=%b rs=%b | flags1=%h cnt1=%0d cx1=%b flags0=%h",
             n_step, reset, en, Cond, FlagW, ALUFlags, CondSample, FlagSave, FlagRestore,
             flags_1, cnt_1, condex_1, flags_0);
    n_step++;
    model_update(0);
    model_update(1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    en = 1'b1; Cond = 4'hE; ALUFlags = 4'h0; FlagW = 2'b00;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
    CondSample = 1'b0; FlagSave = 1'b0; FlagRestore = 1'b0;
  endtask

  logic [15:0] sweep_mask;
  logic        fwd_exp;

  initial begin
    sweep_mask = 16'h66A5;
`ifdef COND_FLAG_FWD_EN
    fwd_exp = 1'b1;
`else
    fwd_exp = 1'b0;
`endif
    // Reset held with every strobe asserted.
    reset = 1'b0; en = 1'b1; Cond = 4'hE; ALUFlags = 4'hF; FlagW = 2'b11;
    PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; NoWrite = 1'b1;
    CondSample = 1'b1; FlagSave = 1'b1; FlagRestore = 1'b1;
    @(negedge clk);
    step(1'b0);
    step(1'b0);
    chk("rst_flags1", 8'(flags_1), 8'h0);
    chk("rst_condex1", 8'(condex_1), 8'h0);
    chk("rst_count1", 8'(cnt_1), 8'h0);
    chk("rst_ovf1", 8'(ovf_1), 8'h0);
    chk("rst_unf1", 8'(unf_1), 8'h0);
    chk("rst_flags0", 8'(flags_0), 8'h0);

    reset = 1'b1; idle();
    CondSample = 1'b1; step(1'b1);
    CondSample = 1'b0; FlagW = 2'b11; ALUFlags = 4'b0110; step(1'b1);
    FlagW = 2'b00;
    chk("load_flags1", 8'(flags_1), 8'h6);
    chk("load_flags0", 8'(flags_0), 8'h6);

    // Sweep all condition codes with only Z and C set.
    RegW = 1'b1;
    for (int c = 0; c < 16; c++) begin
      Cond = 4'(c);
      #1;
      chk($sformatf("sweep_cond%0h", c), 8'(condex_0), 8'(sweep_mask[c]));
      if (c == 15) chk("never_regwrite", 8'(regwrite_0), 8'h0);
      step(1'b1);
    end
    idle();

    // Latched CondEx suppresses a flag write and a memory write.
    CondSample = 1'b1; step(1'b1);
    CondSample = 1'b0; FlagW = 2'b11; ALUFlags = 4'h0; step(1'b1);
    FlagW = 2'b00; Cond = 4'h0; CondSample = 1'b1; step(1'b1);
    CondSample = 1'b0; #1;
    chk("latch_condex", 8'(condex_1), 8'h0);
    FlagW = 2'b10; ALUFlags = 4'b0100; MemW = 1'b1; #1;
    chk("latch_memwrite", 8'(memwrite_1), 8'h0);
    step(1'b1);
    chk("latch_flags", 8'(flags_1), 8'h0);
    idle();

    // Stack fill, overflow, drain, underflow.
    CondSample = 1'b1; step(1'b1);
    CondSample = 1'b0; FlagW = 2'b11; ALUFlags = 4'b1000; step(1'b1);
    FlagW = 2'b00; FlagSave = 1'b1; step(1'b1);
    FlagSave = 1'b0; FlagW = 2'b11; ALUFlags = 4'b0001; step(1'b1);
    FlagW = 2'b00; FlagSave = 1'b1; step(1'b1);
    step(1'b1);
    FlagSave = 1'b0;
    chk("stk_ovf", 8'(ovf_1), 8'h1);
    chk("stk_count_full", 8'(cnt_1), 8'h2);
    FlagRestore = 1'b1; step(1'b1);
    chk("stk_pop1", 8'(flags_1), 8'h1);
    step(1'b1);
    chk("stk_pop2", 8'(flags_1), 8'h8);
    step(1'b1);
    chk("stk_unf", 8'(unf_1), 8'h1);
    chk("stk_unf_flags", 8'(flags_1), 8'h8);
    FlagRestore = 1'b0;

    // Swap with a stall in front of it.
    FlagW = 2'b11; ALUFlags = 4'b0011; step(1'b1);
    FlagW = 2'b00; FlagSave = 1'b1; step(1'b1);
    FlagSave = 1'b0; FlagW = 2'b11; ALUFlags = 4'b1100; step(1'b1);
    FlagW = 2'b00; en = 1'b0; FlagSave = 1'b1; FlagRestore = 1'b1; step(1'b1);
    chk("stall_flags", 8'(flags_1), 8'hC);
    chk("stall_count", 8'(cnt_1), 8'h1);
    en = 1'b1; step(1'b1);
    chk("swap_flags", 8'(flags_1), 8'h3);
    chk("swap_count", 8'(cnt_1), 8'h1);
    FlagSave = 1'b0; step(1'b1);
    chk("swap_top", 8'(flags_1), 8'hC);
    FlagRestore = 1'b0;

    // Sample in the same cycle as a Z update.
    FlagW = 2'b11; ALUFlags = 4'h0; step(1'b1);
    FlagW = 2'b10; ALUFlags = 4'b0100; Cond = 4'h0; CondSample = 1'b1; step(1'b1);
    FlagW = 2'b00; CondSample = 1'b0; #1;
    chk("fwd_condex", 8'(condex_1), 8'(fwd_exp));
    chk("fwd_flags", 8'(flags_1), 8'h4);

    // Random traffic including occasional mid-run resets and stalls.
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(0, 39) != 0);
      en          = ($urandom_range(0, 3) != 0);
      Cond        = 4'($urandom);
      ALUFlags    = 4'($urandom);
      FlagW       = 2'($urandom);
      PCS         = 1'($urandom);
      RegW        = 1'($urandom);
      MemW        = 1'($urandom);
      NoWrite     = 1'($urandom);
      CondSample  = 1'($urandom);
      FlagSave    = ($urandom_range(0, 2) == 0);
      FlagRestore = ($urandom_range(0, 2) == 0);
      step(1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cond_logic_mc.md
Name: cond_logic_mc

Overview:
- Parametrised multicycle successor of the single-cycle condition logic in the ARM processor datapath.
- Holds the architectural NZCV flag register with per-group write enables.
- Evaluates all 16 ARM condition codes, gates PCSrc/RegWrite/MemWrite/flag writes, and optionally latches CondEx for a multicycle controller.
- Adds a small saved-flags stack (push/pop) for exception entry/return. Sits between the controller FSM and the register file / memory / PC mux.

Parameters:
- CONDEX_LATCH, 1, 0 = CondEx combinational from the current flags; 1 = CondEx sampled on CondSample and held.
- SAVE_DEPTH, 2, number of saved-flag stack entries (1..4).
- SDW, $clog2(SAVE_DEPTH+1), width of the SaveCount output (derived; do not override).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- en  in  1  state-update enable; 0 = stall, all registers hold
- Cond  in  4  instruction condition field
- ALUFlags  in  4  {N,Z,C,V} from ALU
- FlagW  in  2  [1]=write N,Z; [0]=write C,V
- PCS, RegW, MemW, NoWrite  in  1 each  controller requests
- CondSample  in  1  capture CondEx (used only when CONDEX_LATCH=1)
- FlagSave  in  1  push current Flags onto stack
- FlagRestore  in  1  pop stack into Flags
- PCSrc, RegWrite, MemWrite  out  1 each  gated requests
- CondEx  out  1  effective condition result
- Flags  out  4  current {N,Z,C,V}
- SaveCount  out  SDW  stack occupancy
- SaveOvf, SaveUnf  out  1 each  sticky overflow/underflow errors

Behaviour:
- Reset (reset==0 at clk edge): Flags=0, CondExReg=0, SaveCount=0, all stack entries=0, SaveOvf=SaveUnf=0. Reset beats en and every strobe; reset in mid-instruction discards the latched CondEx.
- Condition decode on EvalFlags (= Flags; see Optional Feature):
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V)
  - E AL 1; F 0 (never executes)
  - Result is CondComb.
- CONDEX_LATCH=0: CondEx=CondComb, zero latency.
- CONDEX_LATCH=1: on en&CondSample, CondExReg<=CondComb; CondEx=CondExReg (one-cycle latency, holds until the next sample).
- PCSrc=PCS&CondEx; RegWrite=RegW&~NoWrite&CondEx; MemWrite=MemW&CondEx; all combinational, not gated by en.
- Flag write: FlagWrite=FlagW&{2{CondEx}}. When en: FlagWrite[1] loads Flags[3:2] from ALUFlags[3:2]; FlagWrite[0] loads Flags[1:0] from ALUFlags[1:0].
- Stack, when en. Priority order per cycle:
  - Restore & Save together: swap. Flags<=top entry; top<=pre-update Flags; count unchanged. If empty: flags unchanged, SaveUnf=1.
  - Restore only: if count>0, Flags<=top and count-1; else SaveUnf<=1 and Flags unchanged. Restore overrides FlagWrite in the same cycle.
  - Save only: push pre-update Flags, count+1. If count==SAVE_DEPTH, the push is dropped, SaveOvf<=1, and the stack is unchanged. FlagWrite still applies in the same cycle.
- SaveOvf/SaveUnf clear only on reset.
- en==0: no register changes; strobes ignored.

Optional Feature:
- Macro COND_FLAG_FWD_EN.
- Defined and CONDEX_LATCH=1: EvalFlags = Flags with groups replaced by ALUFlags where FlagWrite is asserted this cycle. An instruction sampled in the same cycle as a flag update sees the new flags. No combinational loop, because FlagWrite uses CondExReg.
- Undefined, or CONDEX_LATCH=0: EvalFlags = Flags.

Test Plan:
- Reset: drive reset=0 for 2 clocks with all strobes =1 -> Flags=0, CondEx=0, SaveCount=0, SaveOvf=SaveUnf=0.
- Cond sweep: load Flags=4'b0110 (Z,C) via FlagW=11, CondEx=1. Sweep Cond 0..F -> CondEx true exactly for 0,2,5,7,9,A,D,E (N=0, V=0). Cond=F -> RegWrite=0 with RegW=1.
- Latch (CONDEX_LATCH=1): Flags Z=0, Cond=0, CondSample pulse -> CondEx=0 next cycle. Then FlagW=10 with ALUFlags=4'b0100 -> Flags unchanged (write suppressed). MemW=1 -> MemWrite=0.
- Stack: SAVE_DEPTH=2. Push 4'b1000, then 4'b0001; third push -> SaveOvf=1, SaveCount=2. Pop twice -> Flags=0001 then 1000. Third pop -> SaveUnf=1, Flags=1000.
- Swap and stall: count=1 top=4'b0011, Flags=4'b1100, Save&Restore -> Flags=0011, top=1100. Same strobes with en=0 -> no change.
- COND_FLAG_FWD_EN: CondExReg=1, FlagW=10, ALUFlags Z=1, Cond=0, CondSample in same cycle -> CondEx=1 next cycle. Without the macro -> 0.
